// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges hold requests into one prioritised hold code, arbitrates
// PC redirects (interrupt entry, deferred jump, live jump) onto a single jump
// port, and sequences interrupt entry as drain -> redirect -> acknowledge.
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int HOLD_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_ex_i,
    input  logic              hold_bus_i,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              int_req_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              flush_o,
    output logic              int_ack_o,
    output logic [ADDR_W-1:0] int_epc_o
);

    localparam logic [HOLD_W-1:0] HOLD_NONE = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_PC   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_IF   = HOLD_W'(2);
    localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_REDIRECT
    } state_t;

    state_t            r_state;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [ADDR_W-1:0] r_epc;
    logic [ADDR_W-1:0] r_vector;

    logic [HOLD_W-1:0] w_hold;
    logic              w_free;
    logic              w_redir;
    logic              w_live;
    logic              w_pend_go;
    logic              w_defer;
    logic              w_drain_exit;
    logic              w_jump;
    logic [ADDR_W-1:0] w_jump_addr;

    // Hold code is the largest requested; codes are ordered ID > IF > PC.
    always_comb begin
        w_hold = HOLD_NONE;
        if (hold_ex_i)
            w_hold = HOLD_ID;
        else if (r_state == S_DRAIN)
            w_hold = HOLD_IF;
        else if (hold_bus_i)
            w_hold = HOLD_PC;
    end

    // The PC register drops redirects under hold, so only issue when free.
    // Jumps seen in REDIRECT are dropped entirely: the interrupt wins.
    assign w_free       = (w_hold == HOLD_NONE);
    assign w_redir      = w_free && (r_state == S_REDIRECT);
    assign w_live       = w_free && (r_state != S_REDIRECT) && jump_req_i;
    assign w_pend_go    = w_free && (r_state != S_REDIRECT) && !jump_req_i && r_pend_valid;
    assign w_defer      = !w_free && (r_state != S_REDIRECT) && jump_req_i;
    assign w_drain_exit = (r_state == S_DRAIN) && !hold_ex_i && !hold_bus_i;

    // Redirect source select, highest priority first.
    always_comb begin
        w_jump      = 1'b0;
        w_jump_addr = '0;
        if (w_redir) begin
            w_jump      = 1'b1;
            w_jump_addr = r_vector;
        end else if (w_live) begin
            w_jump      = 1'b1;
            w_jump_addr = jump_addr_i;
        end else if (w_pend_go) begin
            w_jump      = 1'b1;
            w_jump_addr = r_pend_addr;
        end
    end

    // Outputs are forced quiet during the reset cycle regardless of stale state.
    assign hold_flag_o = rst_i ? HOLD_NONE : w_hold;
    assign jump_flag_o = !rst_i && w_jump;
    assign flush_o     = !rst_i && w_jump;
    assign jump_addr_o = rst_i ? '0 : w_jump_addr;
    assign int_ack_o   = !rst_i && w_redir;
    assign int_epc_o   = rst_i ? '0 : r_epc;

    // Interrupt entry sequencer: capture vector, drain, capture EPC, redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_vector <= '0;
            r_epc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (int_req_i) begin
                        r_state  <= S_DRAIN;
                        r_vector <= int_addr_i;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_exit) begin
                        r_state <= S_REDIRECT;
                        // Return to wherever the program would have gone next.
                        if (r_pend_valid)
                            r_epc <= r_pend_addr;
                        else if (jump_req_i)
                            r_epc <= jump_addr_i;
                        else
                            r_epc <= pc_i;
                    end
                end
                S_REDIRECT: begin
                    if (w_free)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Single-entry deferred jump slot, last deferred jump wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else if (w_drain_exit) begin
            // Deferred target was folded into EPC; never issue it.
            r_pend_valid <= 1'b0;
        end else if (w_defer) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= jump_addr_i;
        end else if (w_live || w_pend_go) begin
            r_pend_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic, all
// compared every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, hold_ex, hold_bus, jreq, ireq;
    logic [31:0] jaddr, iaddr, pc;
    logic [2:0]  o_hold;
    logic        o_jump, o_flush, o_ack;
    logic [31:0] o_jaddr, o_epc;

    int n_vec = 0;
    int n_err = 0;
    int acks  = 0;
    int jumps = 0;
    bit last_ack;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .HOLD_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .hold_ex_i(hold_ex), .hold_bus_i(hold_bus),
        .jump_req_i(jreq), .jump_addr_i(jaddr), .int_req_i(ireq),
        .int_addr_i(iaddr), .pc_i(pc), .hold_flag_o(o_hold),
        .jump_flag_o(o_jump), .jump_addr_o(o_jaddr), .flush_o(o_flush),
        .int_ack_o(o_ack), .int_epc_o(o_epc)
    );

    // Behavioural model: interrupt entry is "not started / draining / waiting
    // to redirect"; a jump deferred under hold is remembered as one slot.
    bit          m_draining, m_redirecting, m_pend;
    logic [31:0] m_paddr, m_vec, m_epc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle with the currently driven inputs: check, then advance model.
    task automatic step();
        int          e_hold;
        bit          e_jump, e_ack;
        logic [31:0] e_addr;
        #1;
        e_hold = 0;
        if (hold_bus) e_hold = 1;
        if (m_draining) e_hold = 2;
        if (hold_ex) e_hold = 3;
        e_jump = 0; e_ack = 0; e_addr = 0;
        if (e_hold == 0) begin
            if (m_redirecting) begin e_jump = 1; e_ack = 1; e_addr = m_vec; end
            else if (jreq)     begin e_jump = 1; e_addr = jaddr; end
            else if (m_pend)   begin e_jump = 1; e_addr = m_paddr; end
        end
        if (rst) begin e_hold = 0; e_jump = 0; e_ack = 0; e_addr = 0; end
        chk("hold",  32'(o_hold),  32'(e_hold));
        chk("jump",  32'(o_jump),  32'(e_jump));
        chk("flush", 32'(o_flush), 32'(e_jump));
        chk("jaddr", o_jaddr, e_addr);
        chk("ack",   32'(o_ack),   32'(e_ack));
        chk("epc",   o_epc, rst ? 32'h0 : m_epc);
        last_ack = o_ack;
        if (o_ack) acks++;
        if (o_jump) jumps++;
        @(posedge clk);
        if (rst) begin
            m_draining = 0; m_redirecting = 0; m_pend = 0;
            m_paddr = 0; m_vec = 0; m_epc = 0;
        end else if (m_draining) begin
            if (!hold_ex && !hold_bus) begin
                m_epc = m_pend ? m_paddr : (jreq ? jaddr : pc);
                m_pend = 0;
                m_draining = 0;
                m_redirecting = 1;
            end else if (jreq) begin
                m_pend = 1; m_paddr = jaddr;
            end
        end else if (m_redirecting) begin
            if (e_hold == 0) m_redirecting = 0;
        end else begin
            if (jreq && e_hold != 0) begin m_pend = 1; m_paddr = jaddr; end
            else if (e_hold == 0 && (jreq || m_pend)) m_pend = 0;
            if (ireq) begin m_draining = 1; m_vec = iaddr; end
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        rst = 0; hold_ex = 0; hold_bus = 0; jreq = 0; ireq = 0;
        jaddr = 0; iaddr = 0; pc = 32'h1000;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        int a0, j0;
        idle_in();
        rst = 1;
        m_draining = 0; m_redirecting = 0; m_pend = 0;
        m_paddr = 0; m_vec = 0; m_epc = 0;
        @(negedge clk);
        do_reset();
        // Free run, then a live jump issues in the same cycle.
        step();
        chk("idle_hold", 32'(o_hold), 32'd0);
        jreq = 1; jaddr = 32'h100; #1;
        chk("live_addr", o_jaddr, 32'h100);
        step(); jreq = 0; step();

        // Deferral under bus stall, issued on first free cycle.
        hold_bus = 1; step();
        jreq = 1; jaddr = 32'h200; step(); jreq = 0;
        step(); hold_bus = 0; #1;
        chk("defer_addr", o_jaddr, 32'h200);
        step(); step();

        // Priority: both holds, then live jump beats pending.
        hold_ex = 1; hold_bus = 1; #1;
        chk("hold_max", 32'(o_hold), 32'd3);
        jreq = 1; jaddr = 32'h300; step();
        hold_ex = 0; hold_bus = 0; jaddr = 32'h400; #1;
        chk("live_over_pend", o_jaddr, 32'h400);
        step(); jreq = 0; step(); step();

        // Interrupt during divider busy.
        hold_ex = 1; ireq = 1; iaddr = 32'h80; pc = 32'h1000;
        a0 = acks;
        for (int i = 0; i < 3; i++) begin
            step();
            if (last_ack) ireq = 0;
        end
        hold_ex = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_ack) ireq = 0;
        end
        chk("div_ack_cnt", 32'(acks - a0), 32'd1);
        chk("div_epc", o_epc, 32'h1000);

        // Pending jump absorbed into EPC; only the vector is issued.
        hold_bus = 1; jreq = 1; jaddr = 32'h500; step(); jreq = 0;
        ireq = 1; iaddr = 32'h80; step(); step();
        hold_bus = 0;
        j0 = jumps;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_ack) ireq = 0;
        end
        chk("abs_epc", o_epc, 32'h500);
        chk("abs_jumps", 32'(jumps - j0), 32'd1);

        // Reset in the middle of DRAIN: request never acknowledged.
        hold_ex = 1; ireq = 1; iaddr = 32'h90; step(); step();
        ireq = 0; a0 = acks;
        rst = 1; step(); rst = 0; hold_ex = 0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_no_ack", 32'(acks - a0), 32'd0);

        // Random traffic honouring the interrupt handshake.
        for (int c = 0; c < 3000; c++) begin
            hold_ex  = ($urandom_range(0, 99) < 15);
            hold_bus = ($urandom_range(0, 99) < 20);
            jreq     = ($urandom_range(0, 99) < 30);
            jaddr    = $urandom & 32'hffff_fffc;
            pc       = $urandom & 32'hffff_fffc;
            rst      = ($urandom_range(0, 999) < 5);
            if (ireq && (last_ack || rst)) ireq = 0;
            else if (ireq && $urandom_range(0, 99) < 5) ireq = 0;
            else if (!ireq && $urandom_range(0, 99) < 4) begin
                ireq = 1; iaddr = $urandom & 32'hffff_fffc;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller between the execute stage, bus interface, interrupt source and the PC register / IF-ID pipeline registers. It merges hold requests into one prioritised hold code and arbitrates redirect sources (interrupt entry, deferred jump, live jump) onto a single jump port. It also sequences interrupt entry: drain, redirect, acknowledge. The PC register ignores jumps while any hold is active, so this block defers a jump that arrives under hold and replays it once the hold clears.

Parameters:
ADDR_W, 32, instruction address width
HOLD_W, 3, hold code width; codes: NONE=0, PC=1, IF=2, ID=3 (larger code holds more stages)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
hold_ex_i  in  1  execute multi-cycle op busy (e.g. divider)
hold_bus_i  in  1  instruction/data bus stall
jump_req_i  in  1  execute-stage taken branch/jump
jump_addr_i  in  ADDR_W  target for jump_req_i
int_req_i  in  1  interrupt request, level, held until int_ack_o
int_addr_i  in  ADDR_W  trap vector, stable while int_req_i high
pc_i  in  ADDR_W  current PC register value
hold_flag_o  out  HOLD_W  hold code to PC register and pipeline registers
jump_flag_o  out  1  redirect PC this cycle
jump_addr_o  out  ADDR_W  redirect target
flush_o  out  1  flush IF/ID, asserted exactly with jump_flag_o
int_ack_o  out  1  one-cycle interrupt-taken pulse
int_epc_o  out  ADDR_W  return address captured at interrupt entry

Behaviour:
- Reset, sync and active-high, any state: FSM to IDLE, pend_valid=0, pend_addr=0, epc=0, vector reg=0. All outputs 0 in the reset cycle and in the first cycle after reset (no inputs active).
- hold_flag_o, combinational: maximum of ID if hold_ex_i, PC if hold_bus_i, IF if FSM==DRAIN; otherwise NONE.
- jump_flag_o/jump_addr_o/flush_o, combinational; asserted only when hold_flag_o==NONE. Source priority:
  1. FSM==REDIRECT: vector reg.
  2. Live jump_req_i: jump_addr_i; also clears any pending jump.
  3. pend_valid: pend_addr; clears pend_valid next edge.
- Jump deferral: jump_req_i while hold_flag_o!=NONE sets pend_valid=1 and pend_addr=jump_addr_i next edge. A newer deferred jump overwrites the older one (last wins).
- When not asserted, jump_flag_o=0, flush_o=0, jump_addr_o=0.
- Latency: live jump with no hold reaches the output in the same cycle (0 cycles). Deferred jump issues in the first cycle hold_flag_o==NONE.
- FSM IDLE: int_req_i=1 -> DRAIN next edge; vector reg <= int_addr_i.
- FSM DRAIN: forces hold IF. Jumps arriving in DRAIN are deferred per the rule above.
  - Exit when hold_ex_i==0 and hold_bus_i==0 -> REDIRECT.
  - On that exit edge, epc <= pend_addr if pend_valid, else jump_addr_i if jump_req_i, else pc_i.
  - On that exit edge, pend_valid <= 0 (the deferred target is absorbed into epc, never issued).
- FSM REDIRECT: if hold_flag_o==NONE, then jump_flag_o=1, jump_addr_o=vector, flush_o=1, int_ack_o=1 for this one cycle, then -> IDLE. Otherwise remain in REDIRECT with no ack; hold_bus_i arriving here stalls the redirect.
- jump_req_i in REDIRECT is ignored: not deferred and not issued; the interrupt wins.
- int_epc_o = epc register; updated only on the DRAIN->REDIRECT edge.
- int_req_i dropping during DRAIN: the entry sequence still completes (request already committed).
- int_req_i still high in IDLE after ack: starts a new entry. The requester must drop it on int_ack_o.
- Reset mid-DRAIN or mid-REDIRECT: no ack; pending jump discarded.

Test Plan:
- Free run: no inputs -> hold_flag_o=0, jump_flag_o=0. Then jump_req_i=1, addr 0x100 for one cycle -> same cycle jump_flag_o=1, jump_addr_o=0x100, flush_o=1.
- Deferral: hold_bus_i=1 for cycles 0-2; jump_req_i=1, addr 0x200 at cycle 1 -> hold_flag_o=1 in cycles 0-2, no jump. Cycle 3: jump_flag_o=1, addr 0x200. Cycle 4: idle.
- Priority: hold_ex_i and hold_bus_i both high -> hold_flag_o=3. Pending 0x300 plus live jump 0x400 on hold release -> jump_addr_o=0x400, and pending is not issued afterwards.
- Interrupt during divider: hold_ex_i=1 for 3 cycles, int_req_i with vector 0x80, pc_i=0x1000 -> DRAIN hold_flag_o=3 then 2. REDIRECT cycle: jump 0x80, flush_o=1, int_ack_o=1; int_epc_o=0x1000.
- Pending absorbed: jump 0x500 deferred under bus stall, then interrupt with vector 0x80 -> int_epc_o=0x500, only one jump issued (0x80).
- Reset mid-DRAIN: rst_i pulse -> next cycle all outputs 0, FSM IDLE, no int_ack_o pulse ever appears for that request.
